// File: rtl/topk_pkg.sv
// Shared types and elaboration helpers for the top-K frame sorter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package topk_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SUM     = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Legal kept-entry counts: power of two between 2 and 64.
  function automatic bit depth_ok(input int d);
    return (d >= 2) && (d <= 64) && ((d & (d - 1)) == 0);
  endfunction

  // Sum of d values of w bits each cannot exceed w + log2(d) bits.
  function automatic int sum_width(input int w, input int d);
    return w + $clog2(d);
  endfunction

endpackage

// File: rtl/topk_add_tree.sv
// Pipelined binary adder tree over N unsigned inputs of W bits.
// Latency: $clog2(N) cycles from in_valid to out_valid; output W+$clog2(N) bits.
// Backpressure: none; free-running pipeline, valid travels alongside the data.
// Ports: clk, synrst_n (sync, active-low) | in_valid, in_data[N] | out_valid, out_sum.
module topk_add_tree #(
  parameter int N = 16,
  parameter int W = 12
) (
  input  logic                          clk,
  input  logic                          synrst_n,
  input  logic                          in_valid,
  input  logic [N-1:0][W-1:0]           in_data,
  output logic                          out_valid,
  output logic [W+$clog2(N)-1:0]        out_sum
);

  localparam int L = $clog2(N);

  // Level l holds N>>l partial sums, each W+l bits wide, so no level can overflow.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int NN = N >> l;
    localparam int WW = W + l;
    logic [WW-1:0] node [NN];
    logic          v;

    if (l == 0) begin : g_in
      for (genvar i = 0; i < NN; i++) begin : g_leaf
        assign node[i] = in_data[i];
      end
      assign v = in_valid;
    end else begin : g_add
      // Data registers need no reset: only the valid chain qualifies them.
      always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
          node[i] <= {1'b0, g_lvl[l-1].node[2*i]} + {1'b0, g_lvl[l-1].node[2*i+1]};
        end
      end
      always_ff @(posedge clk) begin
        if (!synrst_n) v <= 1'b0;
        else           v <= g_lvl[l-1].v;
      end
    end
  end

  assign out_sum   = g_lvl[L].node[0];
  assign out_valid = g_lvl[L].v;

endmodule

// File: rtl/topk_frame_sort.sv
// Keeps the DEPTH best samples of a frame sorted, then reports top, sum and count.
// Latency: 1-cycle insert; result valid LOG2D+1 cycles after the in_last handshake.
// Backpressure: in_ready=0 while summing/holding; result held until out_ready.
// Ports: clk, synrst_n (sync, active-low) | in_valid/in_ready/in_data/in_last |
//        out_valid/out_ready/out_top/out_sum/out_count.
module topk_frame_sort #(
  parameter int W        = 12,
  parameter int DEPTH    = 16,
  parameter int LOG2D    = $clog2(DEPTH),
  parameter int MODE_MIN = 0
) (
  input  logic                 clk,
  input  logic                 synrst_n,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_top,
  output logic [W+LOG2D-1:0]   out_sum,
  output logic [LOG2D:0]       out_count
);

  import topk_pkg::*;

  localparam int SW = sum_width(W, DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("topk_frame_sort: DEPTH must be a power of two in 2..64");
  end
  if (LOG2D != $clog2(DEPTH)) begin : g_bad_log2d
    $error("topk_frame_sort: LOG2D is derived from DEPTH and must not be overridden");
  end

  state_t state_q, state_d;

  logic [W-1:0]          slot_dat [DEPTH];
  logic [DEPTH-1:0]      slot_vld;
  logic [W-1:0]          nxt_dat  [DEPTH];
  logic [DEPTH-1:0]      nxt_vld;
  logic [DEPTH-1:0]      better;
  logic [DEPTH-1:0]      better_up;
  logic [DEPTH-1:0][W-1:0] tree_in;
  logic [LOG2D:0]        cnt;
  logic                  accept, tree_go, tree_go_d, capture, out_fire;
  logic                  tree_vld;
  logic [SW-1:0]         tree_sum;

  // A slot yields to the new sample when empty or strictly worse; ties keep
  // arrival order. Because the array is sorted and valid bits are contiguous,
  // this vector is 0...0 1...1 and its first 1 is the insert point.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      better[i] = 1'b0;
      if (!slot_vld[i])          better[i] = 1'b1;
      else if (MODE_MIN != 0)    better[i] = (in_data < slot_dat[i]);
      else                       better[i] = (in_data > slot_dat[i]);
    end
  end

  assign better_up = {better[DEPTH-2:0], 1'b0};

  // Insert point takes the sample, slots below it take their upper neighbour,
  // and the old bottom entry falls off. No better slot means no change.
  always_comb begin
    nxt_dat[0] = better[0] ? in_data : slot_dat[0];
    nxt_vld[0] = better[0] ? 1'b1    : slot_vld[0];
    for (int i = 1; i < DEPTH; i++) begin
      nxt_dat[i] = slot_dat[i];
      nxt_vld[i] = slot_vld[i];
      if (better[i]) begin
        nxt_dat[i] = better_up[i] ? slot_dat[i-1] : in_data;
        nxt_vld[i] = better_up[i] ? slot_vld[i-1] : 1'b1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tree_in[i] = slot_vld[i] ? slot_dat[i] : '0;
      cnt        = cnt + (LOG2D+1)'(slot_vld[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!synrst_n) begin
      slot_vld <= '0;
      for (int i = 0; i < DEPTH; i++) slot_dat[i] <= '0;
    end else if (accept) begin
      slot_vld <= nxt_vld;
      for (int i = 0; i < DEPTH; i++) slot_dat[i] <= nxt_dat[i];
    end else if (out_fire) begin
      slot_vld <= '0;
    end
  end

  // tree_go is a single-cycle pulse in the first SUM cycle; the array is
  // frozen from then until the result is taken.
  topk_add_tree #(
    .N (DEPTH),
    .W (W)
  ) u_tree (
    .clk       (clk),
    .synrst_n  (synrst_n),
    .in_valid  (tree_go),
    .in_data   (tree_in),
    .out_valid (tree_vld),
    .out_sum   (tree_sum)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    tree_go_d = 1'b0;
    capture   = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = synrst_n;
        accept   = in_valid;
        if (in_valid && in_last) begin
          state_d   = SUM;
          tree_go_d = 1'b1;
        end
      end
      SUM: begin
        if (tree_vld) begin
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = COLLECT;
          out_fire = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!synrst_n) begin
      state_q   <= COLLECT;
      tree_go   <= 1'b0;
      out_valid <= 1'b0;
      out_top   <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      state_q <= state_d;
      tree_go <= tree_go_d;
      if (capture) begin
        out_valid <= 1'b1;
        out_top   <= slot_dat[0];
        out_sum   <= tree_sum;
        out_count <= cnt;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_topk_frame_sort.sv
// Bench for topk_frame_sort: max-mode and min-mode instances share one stimulus.
// Latency: checks result arrival at LOG2D+1 cycles after the last handshake.
// Backpressure: holds out_ready low and verifies outputs and in_ready stay frozen.
module tb_topk_frame_sort;

  localparam int W     = 12;
  localparam int DEPTH = 16;
  localparam int LOG2D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               synrst_n, in_valid, in_last, out_ready;
  logic [W-1:0]       in_data;
  logic               rdy_mx, vld_mx, rdy_mn, vld_mn;
  logic [W-1:0]       top_mx, top_mn;
  logic [W+LOG2D-1:0] sum_mx, sum_mn;
  logic [LOG2D:0]     cnt_mx, cnt_mn;

  topk_frame_sort #(.W(W), .DEPTH(DEPTH), .MODE_MIN(0)) u_max (
    .clk(clk), .synrst_n(synrst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy_mx), .out_valid(vld_mx), .out_ready(out_ready),
    .out_top(top_mx), .out_sum(sum_mx), .out_count(cnt_mx));

  topk_frame_sort #(.W(W), .DEPTH(DEPTH), .MODE_MIN(1)) u_min (
    .clk(clk), .synrst_n(synrst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy_mn), .out_valid(vld_mn), .out_ready(out_ready),
    .out_top(top_mn), .out_sum(sum_mn), .out_count(cnt_mn));

  typedef struct packed { int top; int sum; int cnt; } res_t;

  res_t  exp_mx[$], exp_mn[$];
  res_t  e_mx, e_mn;
  int    frm[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    hs_cyc  = 0;
  string cur     = "init";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0d required %0d", cur, name, obs, exp);
    end
  endtask

  // Reference: sort the whole frame, keep the first DEPTH entries.
  function automatic res_t model(input int q[$], input bit mn);
    int   a[$];
    int   t;
    res_t r;
    a = q;
    for (int i = 0; i < a.size(); i++)
      for (int j = 0; j + 1 < a.size() - i; j++)
        if (mn ? (a[j] > a[j+1]) : (a[j] < a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r.cnt = (a.size() > DEPTH) ? DEPTH : a.size();
    r.sum = 0;
    for (int i = 0; i < r.cnt; i++) r.sum += a[i];
    r.top = a[0];
    return r;
  endfunction

  task automatic send(input int d, input bit last);
    check("in_ready", rdy_mx, 1);
    in_valid = 1'b1; in_data = W'(d); in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    frm.push_back(d);
    if (last) begin
      exp_mx.push_back(model(frm, 1'b0));
      exp_mn.push_back(model(frm, 1'b1));
      frm.delete();
      hs_cyc = cyc;
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (!vld_mx && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid", vld_mx, 1);
    if (vld_mx) begin
      check("latency", cyc - hs_cyc, LOG2D + 1);
      check("out_valid_min", vld_mn, 1);
      check("in_ready_sum", rdy_mx, 0);
      if (exp_mx.size() > 0 && exp_mn.size() > 0) begin
        e_mx = exp_mx.pop_front();
        e_mn = exp_mn.pop_front();
        check("top_max",   top_mx, e_mx.top);
        check("sum_max",   sum_mx, e_mx.sum);
        check("count_max", cnt_mx, e_mx.cnt);
        check("top_min",   top_mn, e_mn.top);
        check("sum_min",   sum_mn, e_mn.sum);
        check("count_min", cnt_mn, e_mn.cnt);
      end
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_after_ack", vld_mx, 0);
    check("ready_after_ack", rdy_mx, 1);
    check("top_kept", top_mx, e_mx.top);
  endtask

  initial begin
    synrst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    e_mx = '0; e_mn = '0;
    repeat (3) @(posedge clk);
    #1;
    cur = "reset";
    check("in_ready", rdy_mx, 0);
    check("out_valid", vld_mx, 0);
    check("out_top", top_mx, 0);
    check("out_sum", sum_mx, 0);
    check("out_count", cnt_mx, 0);
    synrst_n = 1'b1;
    #1;
    check("in_ready_release", rdy_mx, 1);
    @(posedge clk); #1;

    cur = "small";
    send(7, 0); send(3, 0); send(9, 0); send(3, 0); send(1, 1);
    wait_result(); ack();

    cur = "ascend";
    for (int v = 1; v <= 20; v++) send(v, v == 20);
    wait_result(); ack();

    cur = "descend";
    for (int v = 20; v >= 1; v--) send(v, v == 1);
    wait_result(); ack();

    cur = "max16";
    for (int k = 0; k < 16; k++) send(4095, k == 15);
    wait_result(); ack();

    cur = "max17";
    for (int k = 0; k < 17; k++) send(4095, k == 16);
    wait_result(); ack();

    cur = "backpressure";
    send(42, 0); send(17, 0); send(99, 1);
    wait_result();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = W'(100 * k + 1); in_last = k[0];
      @(posedge clk); #1;
      check("hold_valid", vld_mx, 1);
      check("hold_ready", rdy_mx, 0);
      check("hold_top", top_mx, e_mx.top);
      check("hold_sum", sum_mx, e_mx.sum);
      check("hold_count", cnt_mx, e_mx.cnt);
    end
    in_valid = 1'b0; in_last = 1'b0;
    ack();

    cur = "after_bp";
    send(5, 1);
    wait_result(); ack();

    cur = "midreset";
    send(100, 0); send(200, 0); send(300, 0);
    frm.delete();
    synrst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", rdy_mx, 0);
    check("rst_top", top_mx, 0);
    check("rst_sum", sum_mx, 0);
    check("rst_count", cnt_mx, 0);
    synrst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_valid", vld_mx, 0);
    check("ready_again", rdy_mx, 1);
    cur = "after_reset";
    send(5, 1);
    wait_result(); ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/topk_frame_sort.md
Name: topk_frame_sort

Overview:
- Parametrised successor to the 16-entry max-keeping insertion sorter.
- Collects a frame of samples and keeps the DEPTH largest values (or smallest, by mode) in a sorted register array with per-slot valid bits.
- At frame end, sums the kept entries through a pipelined adder tree and presents top value, sum and entry count on a valid/ready output.
- Sits between a sample source (e.g. a detector magnitude stream) and downstream statistics logic.

Parameters:
- W, 12, sample width in bits (unsigned).
- DEPTH, 16, number of kept entries; power of two, 2..64.
- LOG2D, $clog2(DEPTH), derived; do not override.
- MODE_MIN, 0, 0 = keep largest DEPTH values; 1 = keep smallest DEPTH values.

Ports:
- clk  in  1  clock.
- synrst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  sample valid.
- in_data  in  W  unsigned sample.
- in_last  in  1  marks the final sample of a frame; qualified by in_valid.
- in_ready  out  1  block accepts samples.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_top  out  W  highest-ranked kept value (maximum, or minimum when MODE_MIN=1).
- out_sum  out  W+LOG2D  sum of valid kept entries.
- out_count  out  LOG2D+1  number of valid kept entries, 1..DEPTH.

Behaviour:
- Reset (synrst_n=0 at a clk edge):
  - all slots cleared and invalidated; state COLLECT.
  - in_ready=0 while reset is asserted, 1 from the first cycle after release.
  - out_valid=0; out_top, out_sum and out_count all 0.
  - reset mid-frame or mid-sum abandons everything; no partial result is emitted.
- States:
  - COLLECT (in_ready=1); SUM (in_ready=0, tree draining); HOLD (in_ready=0, out_valid=1).
- Insertion, COLLECT state, on in_valid & in_ready:
  - slot 0 is the highest rank.
  - the new sample ranks above an entry only when it is strictly better (greater; less when MODE_MIN=1). Equal values keep arrival order, earlier ranks higher.
  - entries below the insert point shift down one slot; the entry in slot DEPTH-1 is evicted if the array is full.
  - if the array is full and the sample is not strictly better than slot DEPTH-1, the sample is discarded and the array is unchanged.
  - invalid slots always accept the sample; valid bits fill contiguously from slot 0.
  - single-cycle insert: the array reflects the sample at the next edge.
- Frame end:
  - an accepted sample with in_last=1 is inserted, then the state moves to SUM on the same edge.
  - in_last without in_valid is ignored.
- SUM:
  - the array is frozen; invalid slots feed 0 into the tree.
  - the tree has LOG2D registered levels, and each level widens by 1 bit, so there is no overflow.
  - out_valid rises exactly LOG2D+1 cycles after the in_last handshake edge; the state moves to HOLD.
- HOLD:
  - out_top, out_sum and out_count are registered and stable while out_valid=1 and out_ready=0.
  - in_valid is ignored.
  - on out_valid & out_ready: all slots are invalidated, out_valid=0 next cycle, state COLLECT, in_ready=1 next cycle.
  - output data holds its last value after the transfer.
- out_count saturates at DEPTH.

Decomposition:
- Package topk_pkg holds:
  - the state enum (COLLECT, SUM, HOLD);
  - the DEPTH legality check (elaboration-time assertion: power of two, 2..64);
  - the width helper for the sum width.
- One natural sub-module, topk_add_tree:
  - parameters N inputs and W width; a pipelined binary adder tree with a valid-in/valid-out shift chain.
  - latency $clog2(N) cycles; output width W+$clog2(N).
- Insertion array and FSM stay in topk_frame_sort.

Test Plan:
- Small frame, W=12, DEPTH=16: frame 7,3,9,3,1 (last on 1) -> out_count=5, out_sum=23, out_top=9, out_valid 5 cycles after the last handshake.
- Overflow and eviction: frame 1..20 ascending, last on 20 -> out_count=16, out_sum=200 (values 5..20), out_top=20. Repeat descending 20..1 -> identical result.
- Width limit: 16 samples of 4095 -> out_sum=65520 (fits 16 bits), out_count=16. A 17th sample of 4095 is discarded (tie, not strictly greater) -> same sum.
- Backpressure:
  - out_ready low for 10 cycles -> outputs constant, in_ready=0, in_valid pulses ignored.
  - then out_ready=1 -> next frame {5} gives out_count=1, out_sum=5, out_top=5, with no carry-over.
- MODE_MIN=1: frame 1..20 -> out_count=16, out_sum=136, out_top=1.
- Reset mid-frame:
  - after 3 samples (100, 200, 300), synrst_n=0 for 1 cycle -> outputs 0, no out_valid.
  - next frame {5, last} -> out_count=1, out_sum=5.
